// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
//
// Command driver for a tinyALU-class datapath. Commands {A, B, op} arrive on a
// valid/ready source and are buffered in a small FIFO. A control FSM pops one
// command at a time, drives the ALU start/done handshake, and places each
// result in an output register that is read through a valid/ready sink.
// A bounded wait on alu_done turns a hung ALU into an error result instead of
// a stalled pipeline.
//
// Parameters
//   DATA_W   operand width; results are 2*DATA_W wide
//   DEPTH    command FIFO entries (power of two, >= 2)
//   TIMEOUT  maximum number of cycles alu_start stays high waiting for done
//
// Ports
//   clk         clock, all logic on the rising edge
//   reset       synchronous, active-high
//   cmd_valid   command offered by the source
//   cmd_ready   FIFO can take a command (low while full or in reset)
//   cmd_a/b     operands
//   cmd_op      000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op,
//               any other code behaves as no_op
//   alu_a/b     operands to the ALU, held between commands
//   alu_op      opcode to the ALU (unknown codes are sent as no_op)
//   alu_start   ALU start, held high until done or timeout
//   alu_reset   two-cycle active-high ALU reset pulse for rst_op
//   alu_done    ALU completion, only looked at while waiting for a result
//   alu_result  ALU result, valid while alu_done is high
//   res_valid   output register holds a result
//   res_ready   sink accepts the result
//   res_data    result (zero when produced by a timeout)
//   res_err     result was produced by a timeout
//   busy        FSM active or commands still queued
// -----------------------------------------------------------------------------
module alu_cmd_driver #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_W-1:0]     cmd_a,
   input  logic [DATA_W-1:0]     cmd_b,
   input  logic [2:0]            cmd_op,

   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [2:0]            alu_op,
   output logic                  alu_start,
   output logic                  alu_reset,
   input  logic                  alu_done,
   input  logic [2*DATA_W-1:0]   alu_result,

   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*DATA_W-1:0]   res_data,
   output logic                  res_err,

   output logic                  busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DEPTH);
   // The wait ends on the edge that would bring the timer to TIMEOUT, so
   // alu_start is high for exactly TIMEOUT cycles when done never comes.
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100,
      OP_RST = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NOP,
      S_RST1,
      S_RST2
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [2:0]        op;
   } cmd_t;

   // ---------------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------------
   cmd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   cmd_t             head;

   assign full  = (count == FIFO_FULL);
   assign empty = (count == '0);
   // No bypass: a full FIFO refuses the push even if the FSM pops this cycle.
   assign cmd_ready = ~full & ~reset;
   assign push      = cmd_valid & cmd_ready;
   assign head      = mem[rd_ptr];

   // NOTE: the storage array has no reset; a flush only clears the pointers
   // and count, so stale entries are never read and the array can map to RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM; all ALU and result outputs are registered
   // ---------------------------------------------------------------------------
   state_e              state,     state_d;
   logic [TMR_W-1:0]    timer,     timer_d;
   logic [DATA_W-1:0]   alu_a_d,   alu_b_d;
   logic [2:0]          alu_op_d;
   logic                alu_start_d;
   logic                alu_reset_d;
   logic                res_valid_d;
   logic [2*DATA_W-1:0] res_data_d;
   logic                res_err_d;
   logic                res_free;

   // The output register is free when empty or being read this cycle, which
   // lets IDLE pop in the same cycle a result is consumed.
   assign res_free = ~res_valid | res_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         timer     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         alu_start <= 1'b0;
         alu_reset <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else begin
         state     <= state_d;
         timer     <= timer_d;
         alu_a     <= alu_a_d;
         alu_b     <= alu_b_d;
         alu_op    <= alu_op_d;
         alu_start <= alu_start_d;
         alu_reset <= alu_reset_d;
         res_valid <= res_valid_d;
         res_data  <= res_data_d;
         res_err   <= res_err_d;
      end
   end

   // NOTE: every signal gets a default before the case statement so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state;
      timer_d     = timer;
      alu_a_d     = alu_a;
      alu_b_d     = alu_b;
      alu_op_d    = alu_op;
      alu_start_d = 1'b0;
      alu_reset_d = 1'b0;
      res_valid_d = res_valid & ~res_ready;
      res_data_d  = res_data;
      res_err_d   = res_err;
      pop         = 1'b0;

      case (state)
         S_IDLE: begin
            if (!empty && res_free) begin
               pop     = 1'b1;
               alu_a_d = head.a;
               alu_b_d = head.b;
               case (head.op)
                  OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                     alu_op_d = head.op;
                     state_d  = S_ISSUE;
                  end
                  OP_RST: begin
                     alu_op_d = OP_RST;
                     state_d  = S_RST1;
                  end
                  default: begin
                     alu_op_d = OP_NOP;
                     state_d  = S_NOP;
                  end
               endcase
            end
         end

         // Operands settle on the ALU for one cycle before start rises.
         S_ISSUE: begin
            alu_start_d = 1'b1;
            timer_d     = '0;
            state_d     = S_WAIT;
         end

         // Done is checked first so it wins over a simultaneous timeout.
         S_WAIT: begin
            if (alu_done) begin
               res_valid_d = 1'b1;
               res_data_d  = alu_result;
               res_err_d   = 1'b0;
               state_d     = S_IDLE;
            end else if (timer >= TMR_LAST) begin
               res_valid_d = 1'b1;
               res_data_d  = '0;
               res_err_d   = 1'b1;
               state_d     = S_IDLE;
            end else begin
               alu_start_d = 1'b1;
               timer_d     = (timer == TMR_MAX) ? timer : timer + 1'b1;
            end
         end

         // no_op is still presented to the ALU as a single start pulse.
         S_NOP: begin
            alu_start_d = 1'b1;
            state_d     = S_IDLE;
         end

         S_RST1: begin
            alu_reset_d = 1'b1;
            state_d     = S_RST2;
         end

         S_RST2: begin
            alu_reset_d = 1'b1;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state != S_IDLE) | ~empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_driver
//
// Directed bench for alu_cmd_driver (DATA_W=8, DEPTH=4, TIMEOUT=8). A small
// behavioural ALU answers alu_start after a programmable latency or stalls.
// Each command that should produce a result pushes its hand-computed expected
// {data, err} into a queue; an independent monitor pops and compares on every
// res_valid && res_ready handshake.
// -----------------------------------------------------------------------------
module tb_alu_cmd_driver;

   localparam int DATA_W  = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_RST = 3'b111;

   logic                clk;
   logic                reset;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [DATA_W-1:0]   cmd_a;
   logic [DATA_W-1:0]   cmd_b;
   logic [2:0]          cmd_op;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [2:0]          alu_op;
   logic                alu_start;
   logic                alu_reset;
   logic                alu_done   = 1'b0;
   logic [2*DATA_W-1:0] alu_result = '0;
   logic                res_valid;
   logic                res_ready;
   logic [2*DATA_W-1:0] res_data;
   logic                res_err;
   logic                busy;

   alu_cmd_driver #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .alu_reset  (alu_reset),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_err    (res_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int accept_cyc = 0;

   always @(posedge clk) cyc++;

   // Activity counters sampled mid-cycle.
   int start_cnt = 0;
   int rst_cnt   = 0;
   int rv_cnt    = 0;
   always @(negedge clk) begin
      if (alu_start) start_cnt++;
      if (alu_reset) rst_cnt++;
      if (res_valid) rv_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural ALU: done after alu_lat start cycles, or never when stalled
   // ---------------------------------------------------------------------------
   logic alu_stall = 1'b0;
   int   alu_lat   = 3;
   int   acnt      = 0;

   function automatic logic [2*DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [2:0] op);
      logic [2*DATA_W-1:0] wa, wb;
      wa = {{DATA_W{1'b0}}, a};
      wb = {{DATA_W{1'b0}}, b};
      case (op)
         OP_ADD:  return wa + wb;
         OP_AND:  return wa & wb;
         OP_XOR:  return wa ^ wb;
         OP_MUL:  return wa * wb;
         default: return '0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (alu_start && !alu_done && !alu_stall) begin
         acnt = acnt + 1;
         if (acnt >= alu_lat) begin
            alu_done   = 1'b1;
            alu_result = alu_fn(alu_a, alu_b, alu_op);
         end
      end else begin
         alu_done = 1'b0;
         acnt     = 0;
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [2*DATA_W-1:0] data;
      logic                err;
   } exp_t;

   exp_t exp_q[$];

   always @(negedge clk) begin
      exp_t e;
      if (!reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got data 0x%0h err %0b, expected no result",
                     res_data, res_err);
         end else begin
            e = exp_q.pop_front();
            check("res_data", 32'(res_data), 32'(e.data));
            check("res_err", 32'(res_err), 32'(e.err));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (always called just after a rising edge)
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      int n;
      n = 0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 60) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", n);
         cmd_valid = 1'b0;
         return;
      end
      tick();
      accept_cyc = cyc;
      cmd_valid  = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [15:0] data, input logic err);
      exp_t e;
      e.data = data;
      e.err  = err;
      exp_q.push_back(e);
      push(a, b, op);
   endtask

   task automatic wait_res(input string name);
      int n;
      n = 0;
      while (!res_valid && n < 60) begin
         tick();
         n++;
      end
      check(name, 32'(res_valid), 32'd1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int n, t0, s0, r0, v0;
      logic stable, started, still_low;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      res_ready = 1'b1;

      tick();
      tick();
      check("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_alu_start", 32'(alu_start), 32'd0);
      check("rst_alu_reset", 32'(alu_reset), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data",  32'(res_data),  32'd0);
      check("rst_alu_a",     32'(alu_a),     32'd0);

      // 1: add FF+01, ALU answers after 3 cycles
      alu_lat = 3;
      push_exp(8'hFF, 8'h01, OP_ADD, 16'h0100, 1'b0);
      t0 = accept_cyc;
      tick();
      check("t1_start_n1", 32'(alu_start), 32'd0);
      tick();
      check("t1_start_n2", 32'(alu_start), 32'd1);
      check("t1_latency",  32'(cyc - t0),  32'd2);
      check("t1_alu_a",    32'(alu_a),     32'hFF);
      check("t1_alu_b",    32'(alu_b),     32'h01);
      check("t1_alu_op",   32'(alu_op),    32'(OP_ADD));
      n = 0;
      while (alu_start && n < 30) begin
         n++;
         tick();
      end
      check("t1_start_cycles", 32'(n), 32'd3);
      check("t1_res_valid", 32'(res_valid), 32'd1);
      check("t1_res_data",  32'(res_data),  32'h0100);
      drain("t1_drain");

      // 2: fill the FIFO behind an unread result, then release it
      res_ready = 1'b0;
      push_exp(8'h10, 8'h20, OP_ADD, 16'h0030, 1'b0);
      wait_res("t2_first_result");
      push_exp(8'h0F, 8'h3C, OP_AND, 16'h000C, 1'b0);
      push_exp(8'hAA, 8'h55, OP_XOR, 16'h00FF, 1'b0);
      push_exp(8'h10, 8'h10, OP_MUL, 16'h0100, 1'b0);
      push_exp(8'h7F, 8'h01, OP_ADD, 16'h0080, 1'b0);
      check("t2_full_ready", 32'(cmd_ready), 32'd0);
      check("t2_full_busy",  32'(busy),      32'd1);
      cmd_a     = 8'h03;
      cmd_b     = 8'h05;
      cmd_op    = OP_MUL;
      cmd_valid = 1'b1;
      still_low = 1'b1;
      repeat (3) begin
         tick();
         if (cmd_ready) still_low = 1'b0;
      end
      check("t2_refused", 32'(still_low), 32'd1);
      check("t2_no_issue", 32'(alu_start), 32'd0);
      res_ready = 1'b1;
      t0 = cyc;
      push_exp(8'h03, 8'h05, OP_MUL, 16'h000F, 1'b0);
      check("t2_fifth_accept", 32'(accept_cyc - t0), 32'd2);
      drain("t2_drain");

      // 3: held result stays stable and blocks the next issue
      res_ready = 1'b0;
      push_exp(8'hFF, 8'hFF, OP_MUL, 16'hFE01, 1'b0);
      push_exp(8'h01, 8'h02, OP_ADD, 16'h0003, 1'b0);
      wait_res("t3_result");
      stable  = 1'b1;
      started = 1'b0;
      repeat (10) begin
         tick();
         if (res_data !== 16'hFE01 || !res_valid) stable = 1'b0;
         if (alu_start) started = 1'b1;
      end
      check("t3_stable",   32'(stable),  32'd1);
      check("t3_no_issue", 32'(started), 32'd0);
      res_ready = 1'b1;
      drain("t3_drain");

      // 4: no_op, rst_op and an undefined code (treated as no_op)
      s0 = start_cnt;
      r0 = rst_cnt;
      v0 = rv_cnt;
      push(8'h00, 8'h00, OP_NOP);
      push(8'h00, 8'h00, OP_RST);
      push(8'h00, 8'h00, 3'b110);
      repeat (14) tick();
      check("t4_start_cycles", 32'(start_cnt - s0), 32'd2);
      check("t4_reset_cycles", 32'(rst_cnt - r0),   32'd2);
      check("t4_no_result",    32'(rv_cnt - v0),    32'd0);
      check("t4_idle",         32'(busy),           32'd0);

      // 5: xor with a stalled ALU times out after TIMEOUT cycles
      alu_stall = 1'b1;
      s0 = start_cnt;
      push_exp(8'h12, 8'h34, OP_XOR, 16'h0000, 1'b1);
      wait_res("t5_result");
      check("t5_res_err", 32'(res_err), 32'd1);
      drain("t5_drain");
      check("t5_start_cycles", 32'(start_cnt - s0), 32'(TIMEOUT));

      // 6: reset during WAIT with two commands queued
      push(8'h11, 8'h22, OP_ADD);
      n = 0;
      while (!alu_start && n < 20) begin
         tick();
         n++;
      end
      check("t6_in_wait", 32'(alu_start), 32'd1);
      push(8'h01, 8'h02, OP_ADD);
      push(8'h03, 8'h04, OP_ADD);
      reset = 1'b1;
      tick();
      check("t6_start_drop", 32'(alu_start), 32'd0);
      check("t6_busy",       32'(busy),      32'd0);
      check("t6_res_valid",  32'(res_valid), 32'd0);
      reset     = 1'b0;
      alu_stall = 1'b0;
      #1;
      check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      s0 = start_cnt;
      v0 = rv_cnt;
      repeat (15) tick();
      check("t6_no_start",  32'(start_cnt - s0), 32'd0);
      check("t6_no_result", 32'(rv_cnt - v0),    32'd0);
      check("t6_idle",      32'(busy),           32'd0);

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
